// File: rtl/mux_pkg.sv
// mux_scan shared types: FSM states and request mode encodings.
// Imported by the scanner top and its testbench.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEL,
    ST_OUT,
    ST_FIN
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_if.sv
// Request/response bundle of the channel scanner.
// master drives requests and READY; slave is the scanner.
interface mux_scan_if #(
  parameter int N = 32,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] I;
  logic [SW-1:0]  S;
  logic           MODE;
  logic [N-1:0]   MASK;
  logic           START;
  logic           READY;
  logic [W-1:0]   Y;
  logic [SW-1:0]  CH;
  logic           VALID;
  logic           ERR;
  logic           DONE;
  logic           BUSY;

  modport master (
    output I, S, MODE, MASK, START, READY,
    input  Y, CH, VALID, ERR, DONE, BUSY
  );

  modport slave (
    input  I, S, MODE, MASK, START, READY,
    output Y, CH, VALID, ERR, DONE, BUSY
  );

endinterface

// File: rtl/mux_prio_find.sv
// Lowest set bit of vec_i at or above ptr_i.
// ptr_i is one bit wider than an index so it can point past N-1.
module mux_prio_find #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [SW:0]   ptr_i,
  output logic          found_o,
  output logic [SW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec_i[k] && ((SW+1)'(k) >= ptr_i)) begin
        found_o = 1'b1;
        idx_o   = SW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Channel mux with direct single-shot and masked ascending scan.
// One registered sample on Y/CH, held under READY backpressure.
module mux_scan
  import mux_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 1
) (
  input logic       CLK,
  input logic       RST,
  mux_scan_if.slave bus
);

  localparam int SW = $clog2(N);
  localparam logic [SW:0] NL = N[SW:0];

  state_e        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW:0]   ptr_q, ptr_d;
  logic [N-1:0]  mask_q, mask_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic [W-1:0]  chan [N];
  logic          found;
  logic [SW-1:0] f_idx;
  logic          s_ok;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign chan[k] = bus.I[k*W +: W];
  end

  assign s_ok = ({1'b0, bus.S} < NL);

  mux_prio_find #(
    .N  (N),
    .SW (SW)
  ) u_find (
    .vec_i   (mask_q),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (f_idx)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          mode_d = bus.MODE;
          if (bus.MODE == MODE_SCAN) begin
            mask_d  = bus.MASK;
            ptr_d   = '0;
            state_d = ST_SEL;
          end else if (s_ok) begin
            y_d     = chan[bus.S];
            ch_d    = bus.S;
            state_d = ST_OUT;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_SEL: begin
        if (found) begin
          y_d     = chan[f_idx];
          ch_d    = f_idx;
          ptr_d   = {1'b0, f_idx} + (SW+1)'(1);
          state_d = ST_OUT;
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_OUT: begin
        if (bus.READY) begin
          if (mode_q == MODE_SCAN) begin
            state_d = ST_SEL;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      mode_q  <= MODE_DIRECT;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.CH    = ch_q;
  assign bus.VALID = (state_q == ST_OUT);
  assign bus.ERR   = err_q;
  assign bus.DONE  = done_q;
  assign bus.BUSY  = (state_q != ST_IDLE);

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter N, default 32, number of input channels (2..64).
REQ-002 Parameter W, default 1, bits per channel (1..32).
REQ-003 Parameter SW, default clog2(N), select/tag width (derived, not overridden).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 I  input  N*W  flattened channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 S  input  SW  channel select for direct mode.
REQ-008 MODE  input  1  0 = direct (single sample of channel S), 1 = scan (all masked-in channels, ascending).
REQ-009 MASK  input  N  scan channel enable, bit k enables channel k.
REQ-010 START  input  1  request pulse; honoured only in IDLE.
REQ-011 Y  output  W  registered selected data.
REQ-012 CH  output  SW  channel index of the data on Y.
REQ-013 VALID  output  1  Y/CH hold a sample not yet accepted.
REQ-014 READY  input  1  consumer accepts; transfer occurs on an edge with VALID=1 and READY=1.
REQ-015 ERR  output  1  one-cycle pulse: direct-mode S >= N.
REQ-016 DONE  output  1  one-cycle pulse: request complete.
REQ-017 BUSY  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, SEL, OUT, FIN; encoding is free.
REQ-019 IDLE + START + MODE=0 + S<N: capture I[S] into Y and S into CH, go to OUT; VALID=1 on the next cycle (latency 1).
REQ-020 IDLE + START + MODE=0 + S>=N: no output, ERR=1 and DONE=1 on the next cycle, stay in IDLE.
REQ-021 IDLE + START + MODE=1: latch MASK into an internal copy, clear scan pointer to 0, go to SEL.
REQ-022 SEL: find the lowest enabled channel >= pointer in latched mask; if found, capture its data/index, set pointer to index+1, go to OUT; if none, go to FIN.
REQ-023 Scan latency: first VALID two cycles after the START edge.
REQ-024 OUT: VALID=1; Y and CH held stable while READY=0 regardless of I changes.
REQ-025 OUT + READY: direct mode -> FIN; scan mode -> SEL; VALID=0 on the following cycle.
REQ-026 FIN: DONE=1 for exactly one cycle, then IDLE.
REQ-027 Scan of MASK all zero: SEL -> FIN, DONE two cycles after START, VALID never asserted.
REQ-028 Scan reaching channel N-1: pointer does not wrap; next SEL goes to FIN.
REQ-029 START outside IDLE, and MASK/S/MODE changes after the START edge, are ignored.
REQ-030 READY while VALID=0 has no effect.

Reset
REQ-031 RST at any edge, including mid-scan or with VALID=1, forces IDLE next cycle; pending sample discarded.
REQ-032 Reset values: Y=0, CH=0, VALID=0, ERR=0, DONE=0, BUSY=0, pointer=0, latched mask=0.
REQ-033 RST has priority over START and READY on the same edge.

Structure
REQ-034 Shared package mux_pkg holds the FSM state enum and the mode constants MODE_DIRECT and MODE_SCAN.
REQ-035 One sub-module, mux_prio_find: combinational lowest-set-bit-at-or-above-pointer search over N bits, outputs found flag and index.
REQ-036 The channel selection mux is combinational indexing of I; only Y/CH/control are registered.

Verification
REQ-037 N=32,W=1: direct START with S=0..31, one-hot I matching S, READY=1 -> Y=1, CH=S, VALID one cycle after START, DONE one cycle after accept.
REQ-038 N=8,W=4: MASK=8'b1010_0101, scan, READY=1 -> CH sequence 0,2,5,7 with matching Y; DONE after the CH=7 transfer; BUSY high throughout.
REQ-039 Backpressure: READY=0 for 5 cycles in OUT while I toggles -> Y/CH/VALID unchanged; transfer on the first READY=1 edge.
REQ-040 N=20: direct S=25 -> ERR=1 and DONE=1 next cycle, VALID stays 0; scan with MASK=0 -> DONE two cycles after START, no VALID.
REQ-041 RST asserted during a scan with VALID=1 -> all outputs at reset values next cycle; a new START then proceeds normally.
REQ-042 START pulsed while BUSY=1 -> ignored; CH sequence of the active scan unchanged.
